posit_dot_sequencer: RTL and testbench

//  Job-level controller for the posit MAC/accumulate pipeline.

---
 rtl/posit_pkg.sv | 28 ++
 rtl/posit_dot_sequencer_if.sv | 31 +++
 rtl/posit_result_reg.sv | 44 ++++
 rtl/posit_dot_sequencer.sv | 104 ++++++++++
 tb/tb_posit_dot_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared constants and FSM encoding for the posit dot-product job sequencer.
// Default configuration: 8-bit posits, 2 exponent bits, 9-term dot products.
package posit_pkg;

    localparam int POSIT_WIDTH = 8;
    localparam int POSIT_EXP   = 2;
    localparam int DOT_K       = 9;

    localparam int BIAS    = (2 ** (POSIT_EXP + 1)) * (POSIT_WIDTH - 2);
    localparam int WK      = $clog2(DOT_K);
    localparam int WIDTH_A = WK + 2 * BIAS + 2;

    localparam int VLD_W    = 15;
    localparam int VLD_KEEP = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } seq_state_e;

    // Accumulator width for an arbitrary posit configuration.
    function automatic int acc_width(input int width, input int exp, input int k);
        return $clog2(k) + 2 * ((2 ** (exp + 1)) * (width - 2)) + 2;
    endfunction

endpackage

// File: rtl/posit_dot_sequencer_if.sv
// Job, operand, pipeline-valid, accumulator and result signals of the dot-product sequencer.
// slave is the sequencer side, master is the job source / pipeline / consumer side.
interface posit_dot_sequencer_if
    import posit_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int DAT_W = posit_pkg::WIDTH_A
);
    logic             job_valid;
    logic             job_ready;
    logic [ID_W-1:0]  job_id;
    logic             in_valid;
    logic             in_ready;
    logic [VLD_W-1:0] vld_d;
    logic             acc_rdy;
    logic [DAT_W-1:0] acc;
    logic             res_valid;
    logic             res_ready;
    logic [DAT_W-1:0] res_data;
    logic [ID_W-1:0]  res_id;

    modport slave (
        input  job_valid, job_id, in_valid, acc_rdy, acc, res_ready,
        output job_ready, in_ready, vld_d, res_valid, res_data, res_id
    );

    modport master (
        output job_valid, job_id, in_valid, acc_rdy, acc, res_ready,
        input  job_ready, in_ready, vld_d, res_valid, res_data, res_id
    );
endinterface

// File: rtl/posit_result_reg.sv
// Single-entry valid/ready holding register for a tagged accumulator result.
// Latency: 1 cycle capture-to-valid; backpressure: cap_rdy low while full and not being drained.
module posit_result_reg #(
    parameter int DAT_W = 102,
    parameter int ID_W  = 4
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             cap_vld,
    output logic             cap_rdy,
    input  logic [DAT_W-1:0] cap_dat,
    input  logic [ID_W-1:0]  cap_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DAT_W-1:0] res_data,
    output logic [ID_W-1:0]  res_id
);
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [DAT_W-1:0] dat;
    } res_t;

    res_t hold_q;
    logic vld_q;

    assign cap_rdy = ~vld_q | res_ready;

    // A capture in the same cycle as a drain wins: the register stays full with new data.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            hold_q <= '0;
        end else if (cap_vld) begin
            vld_q  <= 1'b1;
            hold_q <= '{id: cap_id, dat: cap_dat};
        end else if (res_ready) begin
            vld_q  <= 1'b0;
        end
    end

    assign res_valid = vld_q;
    assign res_data  = hold_q.dat;
    assign res_id    = hold_q.id;
endmodule

// File: rtl/posit_dot_sequencer.sv
// Job sequencer for the posit MAC pipeline: gates K operand pairs per job, drives stage valids, returns tagged sums.
// Latency: last operand at t -> acc_rdy t+7, capture t+7, flush t+8, next job_ready t+9 (job period K+9).
// Backpressure: operand stalls never clear the partial sum; a full result register holds the job in DRAIN.
module posit_dot_sequencer
    import posit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EXP   = 2,
    parameter int K     = 9,
    parameter int ID_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn,
    posit_dot_sequencer_if.slave  io
);
    localparam int ACC_W = acc_width(WIDTH, EXP, K);
    localparam int CNT_W = $clog2(K) + 1;

    seq_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [ID_W-1:0]       id_q;
    logic [VLD_KEEP-2:0]   chain;
    logic                  job_rdy_q;
    logic                  in_rdy_q;
    logic                  in_fire;
    logic                  job_fire;
    logic                  cap_vld;
    logic                  cap_rdy;
    logic [VLD_W-1:0]      vld;

    assign in_fire  = io.in_valid & in_rdy_q;
    assign job_fire = io.job_valid & job_rdy_q;
    assign cap_vld  = (state == DRAIN) & io.acc_rdy & cap_rdy;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            id_q      <= '0;
            chain     <= '0;
            job_rdy_q <= 1'b0;
            in_rdy_q  <= 1'b0;
        end else begin
            chain <= {chain[VLD_KEEP-3:0], in_fire};
            case (state)
                IDLE: begin
                    job_rdy_q <= 1'b1;
                    if (job_fire) begin
                        id_q      <= io.job_id;
                        cnt       <= '0;
                        job_rdy_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (in_fire) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(K - 1)) begin
                            in_rdy_q <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cap_vld) state <= FLUSH;
                end
                FLUSH: begin
                    chain     <= '0;
                    job_rdy_q <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 is the issue cycle itself, so vld_d[k] marks an operand issued k cycles ago.
    always_comb begin
        vld = '0;
        if (state != FLUSH) vld[VLD_KEEP-1:0] = {chain, in_fire};
        vld[VLD_KEEP] = (state == ISSUE) || (state == DRAIN);
    end

    assign io.vld_d     = vld;
    assign io.job_ready = job_rdy_q;
    assign io.in_ready  = in_rdy_q;

    posit_result_reg #(
        .DAT_W (ACC_W),
        .ID_W  (ID_W)
    ) u_res (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .cap_vld   (cap_vld),
        .cap_rdy   (cap_rdy),
        .cap_dat   (io.acc),
        .cap_id    (id_q),
        .res_valid (io.res_valid),
        .res_ready (io.res_ready),
        .res_data  (io.res_data),
        .res_id    (io.res_id)
    );
endmodule

// File: tb/tb_posit_dot_sequencer.sv
// Directed bench for posit_dot_sequencer with a behavioural accumulator raising acc_rdy two cycles after the K-th vld_d[5].
module tb_posit_dot_sequencer;
    localparam int K     = 9;
    localparam int ID_W  = 4;
    localparam int ACC_W = posit_pkg::WIDTH_A;

    logic clk_i = 1'b0;
    logic rstn  = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    posit_dot_sequencer_if #(.ID_W(ID_W), .DAT_W(ACC_W)) bus ();

    posit_dot_sequencer #(
        .WIDTH (8),
        .EXP   (2),
        .K     (K),
        .ID_W  (ID_W)
    ) dut (
        .clk_i (clk_i),
        .rstn  (rstn),
        .io    (bus)
    );

    // Accumulator model: cleared whenever vld_d is all-zero.
    int   n5 = 0;
    bit   pend = 1'b0;
    logic nxt_rdy = 1'b0;
    always @(negedge clk_i) begin
        if (bus.vld_d == '0) begin
            n5 = 0; pend = 1'b0; nxt_rdy = 1'b0;
        end else begin
            if (pend) nxt_rdy = 1'b1;
            pend = 1'b0;
            if (bus.vld_d[5]) begin
                n5++;
                if (n5 == K) pend = 1'b1;
            end
        end
    end
    always @(posedge clk_i) begin
        #1;
        bus.acc_rdy = nxt_rdy;
    end

    // Every result handed to the consumer, in order.
    logic [ID_W-1:0]  q_id[$];
    logic [ACC_W-1:0] q_dat[$];
    always @(negedge clk_i) begin
        if (rstn && bus.res_valid && bus.res_ready) begin
            q_id.push_back(bus.res_id);
            q_dat.push_back(bus.res_data);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [ID_W-1:0] eid, input logic [ACC_W-1:0] edat);
        logic [ID_W-1:0]  gid;
        logic [ACC_W-1:0] gdat;
        chk({tag, "_present"}, 128'(q_id.size() > 0), 128'(1));
        if (q_id.size() > 0) begin
            gid  = q_id.pop_front();
            gdat = q_dat.pop_front();
            chk({tag, "_id"}, 128'(gid), 128'(eid));
            chk({tag, "_data"}, 128'(gdat), 128'(edat));
        end
    endtask

    // Per-job measurements.
    int m_fire, m_v5, m_nokeep, m_jrhi, m_accn, m_acc, m_last, m_flush, m_jr, m_jf;

    // hold: 0 -> res_ready always 1, <0 -> always 0, >0 -> low until acc_rdy seen hold times.
    task automatic run_job(input logic [ID_W-1:0] id, input logic [ACC_W-1:0] dat,
                           input int stall_after, input int stall_len, input int hold, input bit keep_jv);
        int n;
        int st;
        bit done;
        m_fire = 0; m_v5 = 0; m_nokeep = 0; m_jrhi = 0; m_accn = 0;
        m_acc = -1; m_last = -1; m_flush = -1; st = 0; done = 1'b0;
        bus.acc = dat;
        bus.job_id = id;
        bus.job_valid = 1'b1;
        n = 0;
        while (!bus.job_ready && n < 100) begin @(negedge clk_i); n++; end
        chk("job_accept_timeout", 128'(n >= 100), 128'(0));
        m_jf = cyc;
        @(posedge clk_i); #1;
        bus.job_valid = keep_jv;
        if (keep_jv) bus.job_id = id + 1'b1;
        n = 0;
        while (!done && n < 400) begin
            if (m_fire == stall_after && st < stall_len) begin
                bus.in_valid = 1'b0;
                st++;
            end else begin
                bus.in_valid = 1'b1;
            end
            bus.res_ready = (hold == 0) ? 1'b1 : (hold > 0 && m_accn >= hold);
            @(negedge clk_i);
            if (bus.in_valid && bus.in_ready) begin m_fire++; m_last = cyc; end
            if (bus.vld_d[5]) m_v5++;
            if (bus.job_ready) m_jrhi++;
            if (bus.vld_d == '0) begin
                m_flush = cyc;
                done = 1'b1;
            end else begin
                if (!bus.vld_d[14]) m_nokeep++;
                if (bus.acc_rdy) begin
                    if (m_accn == 0) m_acc = cyc;
                    m_accn++;
                end
            end
            n++;
            if (!done) begin @(posedge clk_i); #1; end
        end
        chk("job_flush_timeout", 128'(done), 128'(1));
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.job_ready && n < 100) begin @(negedge clk_i); n++; end
        chk("job_idle_timeout", 128'(n >= 100), 128'(0));
        m_jr = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACC_W-1:0] d_a, d_b, d_c;
        int jf3, n;
        bus.job_valid = 1'b0; bus.job_id = '0; bus.in_valid = 1'b0;
        bus.acc_rdy = 1'b0; bus.acc = '0; bus.res_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_job_ready", 128'(bus.job_ready), 128'(0));
        chk("rst_in_ready",  128'(bus.in_ready),  128'(0));
        chk("rst_vld_d",     128'(bus.vld_d),     128'(0));
        chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
        chk("rst_res_data",  128'(bus.res_data),  128'(0));
        chk("rst_res_id",    128'(bus.res_id),    128'(0));
        @(posedge clk_i); #1;
        rstn = 1'b1;

        // 1: plain job, acc = -37
        d_a = -37;
        run_job(4'd2, d_a, -1, 0, 0, 1'b0);
        chk("t1_fires",      128'(m_fire), 128'(K));
        chk("t1_v5_count",   128'(m_v5), 128'(K));
        chk("t1_acc_rdy_lat",128'(m_acc - m_last), 128'(7));
        chk("t1_flush_lat",  128'(m_flush - m_last), 128'(8));
        chk("t1_ready_lat",  128'(m_jr - m_last), 128'(9));
        chk("t1_keepalive",  128'(m_nokeep), 128'(0));
        chk("t1_no_jobrdy",  128'(m_jrhi), 128'(0));
        chk_res("t1_res", 4'd2, d_a);

        // 2: 20-cycle operand stall after term 4
        d_a = 1234;
        run_job(4'd4, d_a, 4, 20, 0, 1'b0);
        chk("t2_fires",      128'(m_fire), 128'(K));
        chk("t2_keepalive",  128'(m_nokeep), 128'(0));
        chk("t2_v5_count",   128'(m_v5), 128'(K));
        chk("t2_job_len",    128'(m_flush - m_jf), 128'(K + 20 + 8));
        chk_res("t2_res", 4'd4, d_a);

        // 3: result A held, job B waits in DRAIN until A drains
        d_a = -5;
        d_b = 77;
        run_job(4'd10, d_a, -1, 0, -1, 1'b0);
        chk("t3a_acc_cycles", 128'(m_accn), 128'(1));
        chk("t3a_held",       128'(bus.res_valid), 128'(1));
        chk("t3a_not_taken",  128'(q_id.size()), 128'(0));
        run_job(4'd11, d_b, -1, 0, 5, 1'b0);
        chk("t3b_acc_cycles", 128'(m_accn), 128'(6));
        chk("t3b_flush_wait", 128'(m_flush - m_acc), 128'(6));
        chk_res("t3_first", 4'd10, d_a);
        chk_res("t3_second", 4'd11, d_b);

        // 4: back-to-back ids 3 then 5
        d_a = 300;
        d_b = -300;
        run_job(4'd3, d_a, -1, 0, 0, 1'b0);
        jf3 = m_jf;
        chk("t4_fires_3", 128'(m_fire), 128'(K));
        run_job(4'd5, d_b, -1, 0, 0, 1'b0);
        chk("t4_fires_5", 128'(m_fire), 128'(K));
        chk("t4_period",  128'(m_jf - jf3), 128'(K + 9));
        chk_res("t4_first", 4'd3, d_a);
        chk_res("t4_second", 4'd5, d_b);

        // 5: reset during DRAIN, then a normal job
        bus.acc = 99;
        bus.job_id = 4'd7;
        bus.job_valid = 1'b1;
        n = 0;
        while (!bus.job_ready && n < 100) begin @(negedge clk_i); n++; end
        @(posedge clk_i); #1;
        bus.job_valid = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (bus.in_ready && n < 50);
        chk("t5_drain_timeout", 128'(n >= 50), 128'(0));
        @(posedge clk_i); #1;
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk_i);
        chk("t5_job_ready",  128'(bus.job_ready), 128'(0));
        chk("t5_in_ready",   128'(bus.in_ready),  128'(0));
        chk("t5_vld_d",      128'(bus.vld_d),     128'(0));
        chk("t5_res_valid",  128'(bus.res_valid), 128'(0));
        chk("t5_res_data",   128'(bus.res_data),  128'(0));
        chk("t5_res_id",     128'(bus.res_id),    128'(0));
        @(posedge clk_i); #1;
        rstn = 1'b1;
        d_a = 4242;
        run_job(4'd8, d_a, -1, 0, 0, 1'b0);
        chk("t5_fires", 128'(m_fire), 128'(K));
        chk("t5_no_stale", 128'(q_id.size()), 128'(1));
        chk_res("t5_res", 4'd8, d_a);

        // 6: job_valid held through the job with a changing id
        d_b = -1;
        d_c = 17;
        run_job(4'd6, d_b, -1, 0, 0, 1'b1);
        chk("t6_no_jobrdy", 128'(m_jrhi), 128'(0));
        jf3 = m_jr;
        run_job(4'd9, d_c, -1, 0, 0, 1'b0);
        chk("t6_next_accept", 128'(m_jf), 128'(jf3));
        chk_res("t6_first", 4'd6, d_b);
        chk_res("t6_second", 4'd9, d_c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
